st_bresp_resend_sched: RTL and testbench
========================================

// Module: st_bresp_resend_sched
// PURPOSE
//  Write-response tracker and resend scheduler for the store path. Counts AXI B responses of one
//  store instruction, records failing beats in a 256-entry error bitmap (indexed by oram/sram addr),
//  then replays each failing address through a valid/ready resend port, lowest address first.
//  Repeats rounds until all responses are OKAY or MAX_RETRY rounds are used. Sits beside the store buffer.
// PARAMETERS
//  ENTRY_NUM  256  bitmap entries; one per sram line address
//  ADDR_W     8    log2(ENTRY_NUM); width of response/resend addresses
//  CNT_W      9    response counter width; holds 0..ENTRY_NUM
//  MAX_RETRY  3    max resend rounds before the error is reported
// PORTS
//  clk        in   1       clock; all logic rising-edge
//  rst        in   1       synchronous, active-high reset
//  start_vld  in   1       store accepted (awvld&awrdy); sampled only in IDLE
//  start_cnt  in   CNT_W   B responses expected for this store; >ENTRY_NUM saturates to ENTRY_NUM
//  bvld       in   1       write response valid
//  bresp      in   2       AXI resp; 2'b00 = OKAY, any nonzero = error
//  baddr      in   ADDR_W  oram/sram addr tagged on the response
//  brdy       out  1       response ready
//  rs_vld     out  1       resend request valid
//  rs_addr    out  ADDR_W  sram addr to replay
//  rs_rdy     in   1       resend request accepted by store buffer
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse: instruction finished (clean or failed)
//  err        out  1       1-cycle pulse with done: retries exhausted, bitmap still nonzero
//  retry_cnt  out  2       resend rounds used in current instruction
// BEHAVIOUR
//  Reset: state=IDLE; bitmap, issue mask, counters cleared; brdy=rs_vld=busy=done=err=0; retry_cnt=0.
//  Reset mid-operation aborts everything; no done/err pulse is generated.
//  States: IDLE -> COLLECT -> (RESEND -> COLLECT)* -> IDLE. All state and outputs change on clk edge.
//  IDLE: brdy=0, rs_vld=0. start_vld=1 -> COLLECT; bitmap=0, resp_cnt=0, expect=sat(start_cnt), retry=0.
//   start_vld outside IDLE is ignored.
//  Response handshake (COLLECT and RESEND): brdy=1; on bvld&brdy: bitmap[baddr] <= |bresp
//   (error sets, OKAY clears - last response wins), resp_cnt <= resp_cnt+1.
//  COLLECT exit, evaluated on bitmap/resp_cnt after this cycle's handshake (resp_cnt_nxt==expect):
//   bitmap_nxt==0 -> IDLE, done=1 next cycle.
//   bitmap_nxt!=0 and retry==MAX_RETRY -> IDLE, done=1 and err=1 next cycle.
//   otherwise -> RESEND; issue_mask <= bitmap_nxt; retry++; resp_cnt <= 0; issued <= 0.
//   expect==0 on entry: exit condition true in the first COLLECT cycle (done one cycle later, no bvld needed).
//  RESEND: rs_vld = |issue_mask; rs_addr = index of lowest set bit of issue_mask (combinational
//   two-level: 8 banks x 32, first nonzero bank then first bit). rs_addr stable while rs_vld&!rs_rdy.
//   On rs_vld&rs_rdy: clear that bit in issue_mask, issued++. Throughput one resend per cycle.
//   When issue_mask becomes 0 -> COLLECT with expect=issued; responses already counted in RESEND are kept.
//  Bitmap bits cleared only by OKAY responses or reset/start; issue_mask never affects bitmap.
//  Responses in IDLE are not accepted (brdy=0). Counter overflow impossible: expect<=ENTRY_NUM.
//  Latency: last response handshake at cycle N -> done at N+1; first rs_vld at N+1 when resending.
// TESTING
//  T1 clean: start_cnt=4, 4 OKAY responses addr 0..3 -> done pulse cycle after 4th, err=0, retry_cnt=0.
//  T2 one error: start_cnt=4, addr 2 bresp=2'b10 -> RESEND, rs_vld rs_addr=2; rs_rdy; OKAY on 2 -> done, retry_cnt=1.
//  T3 ordering/backpressure: errors at addr 200,5,37, rs_rdy low 3 cycles -> rs_addr held 5, then 37, 200.
//  T4 exhaustion: addr 9 errors every round -> 3 resend rounds, then done=err=1, busy=0.
//  T5 edges: start_cnt=0 -> done 2 cycles after start; start_cnt=300 -> expect 256; start_vld while busy ignored.
//  T6 reset in RESEND with rs_vld=1 -> next cycle rs_vld=0, brdy=0, busy=0, no done/err pulse.

Source files
------------

// File: rtl/st_bresp_resend_sched.sv
// Store-path write-response tracker: collects B responses into an error bitmap, then replays
// failing addresses lowest-first through a valid/ready resend port, for up to MAX_RETRY rounds.
module st_bresp_resend_sched #(
  parameter int ENTRY_NUM = 256,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 9,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_vld_i,
  input  logic [CNT_W-1:0]  start_cnt_i,
  input  logic              bvld_i,
  input  logic [1:0]        bresp_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              brdy_o,
  output logic              rs_vld_o,
  output logic [ADDR_W-1:0] rs_addr_o,
  input  logic              rs_rdy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        retry_cnt_o
);

  // state   | meaning
  // IDLE    | waiting for a store; responses not accepted
  // COLLECT | counting B responses until the expected number has arrived
  // RESEND  | replaying failing addresses; responses still accepted
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESEND} state_t;

  localparam int BANKS   = 8;
  localparam int BANK_W  = ENTRY_NUM / BANKS;
  localparam int BANK_AW = $clog2(BANKS);
  localparam int BIT_AW  = ADDR_W - BANK_AW;

  state_t               state_q, state_d;
  logic [ENTRY_NUM-1:0] bitmap_q, bitmap_d, bitmap_nxt;
  logic [ENTRY_NUM-1:0] mask_q, mask_d, mask_nxt;
  logic [CNT_W-1:0]     resp_cnt_q, resp_cnt_d, resp_cnt_nxt;
  logic [CNT_W-1:0]     expect_q, expect_d;
  logic [CNT_W-1:0]     issued_q, issued_d, issued_nxt;
  logic [1:0]           retry_q, retry_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 b_hs, rs_fire;

  logic [BANK_AW-1:0]   bank_sel;
  logic [BIT_AW-1:0]    bit_sel;
  logic [BANK_W-1:0]    bank_bits;
  logic                 bank_found, bit_found;

  assign brdy_o      = (state_q != S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rs_vld_o    = (state_q == S_RESEND) && (|mask_q);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign retry_cnt_o = retry_q;

  // Two-level lowest-set-bit search: first nonzero bank, then first bit within it.
  always_comb begin
    bank_sel   = '0;
    bank_found = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (!bank_found && (|mask_q[b*BANK_W +: BANK_W])) begin
        bank_sel   = BANK_AW'(b);
        bank_found = 1'b1;
      end
    end
    bank_bits = mask_q[bank_sel*BANK_W +: BANK_W];
    bit_sel   = '0;
    bit_found = 1'b0;
    for (int i = 0; i < BANK_W; i++) begin
      if (!bit_found && bank_bits[i]) begin
        bit_sel   = BIT_AW'(i);
        bit_found = 1'b1;
      end
    end
    rs_addr_o = {bank_sel, bit_sel};
  end

  always_comb begin
    b_hs         = bvld_i & brdy_o;
    rs_fire      = rs_vld_o & rs_rdy_i;
    bitmap_nxt   = bitmap_q;
    if (b_hs) bitmap_nxt[baddr_i] = |bresp_i;
    resp_cnt_nxt = resp_cnt_q + CNT_W'(b_hs);
    mask_nxt     = mask_q;
    if (rs_fire) mask_nxt[rs_addr_o] = 1'b0;
    issued_nxt   = issued_q + CNT_W'(rs_fire);

    state_d    = state_q;
    bitmap_d   = bitmap_q;
    mask_d     = mask_q;
    resp_cnt_d = resp_cnt_q;
    expect_d   = expect_q;
    issued_d   = issued_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_vld_i) begin
          state_d    = S_COLLECT;
          bitmap_d   = '0;
          mask_d     = '0;
          resp_cnt_d = '0;
          issued_d   = '0;
          retry_d    = '0;
          expect_d   = (start_cnt_i > CNT_W'(ENTRY_NUM)) ? CNT_W'(ENTRY_NUM) : start_cnt_i;
        end
      end
      S_COLLECT: begin
        bitmap_d   = bitmap_nxt;
        resp_cnt_d = resp_cnt_nxt;
        if (resp_cnt_nxt == expect_q) begin
          if (bitmap_nxt == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (retry_q == 2'(MAX_RETRY)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = S_RESEND;
            mask_d     = bitmap_nxt;
            retry_d    = retry_q + 2'd1;
            resp_cnt_d = '0;
            issued_d   = '0;
          end
        end
      end
      S_RESEND: begin
        bitmap_d   = bitmap_nxt;
        resp_cnt_d = resp_cnt_nxt;
        mask_d     = mask_nxt;
        issued_d   = issued_nxt;
        // Responses that already arrived during the replay stay counted.
        if (mask_nxt == '0) begin
          state_d  = S_COLLECT;
          expect_d = issued_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bitmap_q   <= '0;
      mask_q     <= '0;
      resp_cnt_q <= '0;
      expect_q   <= '0;
      issued_q   <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      mask_q     <= mask_d;
      resp_cnt_q <= resp_cnt_d;
      expect_q   <= expect_d;
      issued_q   <= issued_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_st_bresp_resend_sched.sv
// Directed bench for st_bresp_resend_sched: a vector table for the simple flows and
// hand-written sequences for backpressure, retry exhaustion, saturation and reset abort.
module tb_st_bresp_resend_sched;

  logic       clk = 1'b0;
  logic       rst, start_vld, bvld, rs_rdy;
  logic [8:0] start_cnt;
  logic [1:0] bresp;
  logic [7:0] baddr;
  logic       brdy, rs_vld, busy, done, err;
  logic [7:0] rs_addr;
  logic [1:0] retry_cnt;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  st_bresp_resend_sched dut (
    .clk_i(clk), .rst_i(rst), .start_vld_i(start_vld), .start_cnt_i(start_cnt),
    .bvld_i(bvld), .bresp_i(bresp), .baddr_i(baddr), .brdy_o(brdy),
    .rs_vld_o(rs_vld), .rs_addr_o(rs_addr), .rs_rdy_i(rs_rdy),
    .busy_o(busy), .done_o(done), .err_o(err), .retry_cnt_o(retry_cnt)
  );

  typedef struct {
    logic       rst;
    logic       sv;
    logic [8:0] cnt;
    logic       bv;
    logic [1:0] br;
    logic [7:0] ba;
    logic       rr;
    logic       e_brdy;
    logic       e_rsv;
    logic [7:0] e_addr;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic [1:0] e_retry;
  } vec_t;

  vec_t vecs[18];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [8:0] cnt, input logic bv,
                       input logic [1:0] br, input logic [7:0] ba, input logic rr);
    rst = r; start_vld = sv; start_cnt = cnt; bvld = bv; bresp = br; baddr = ba; rs_rdy = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic e_brdy, input logic e_rsv, input logic [7:0] e_addr,
                       input logic e_busy, input logic e_done, input logic e_err, input logic [1:0] e_retry);
    cmp({tag, ".brdy"}, 32'(brdy), 32'(e_brdy));
    cmp({tag, ".rs_vld"}, 32'(rs_vld), 32'(e_rsv));
    if (e_rsv) cmp({tag, ".rs_addr"}, 32'(rs_addr), 32'(e_addr));
    cmp({tag, ".busy"}, 32'(busy), 32'(e_busy));
    cmp({tag, ".done"}, 32'(done), 32'(e_done));
    cmp({tag, ".err"}, 32'(err), 32'(e_err));
    cmp({tag, ".retry"}, 32'(retry_cnt), 32'(e_retry));
  endtask

  initial begin
    //            rst sv cnt bv br    ba rr  brdy rsv addr busy done err retry
    vecs[0]  = '{1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // reset
    vecs[1]  = '{0, 1, 4, 0, 2'b00, 0, 0,  1, 0, 0, 1, 0, 0, 0};  // T1 start
    vecs[2]  = '{0, 0, 0, 1, 2'b00, 0, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 2'b00, 1, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 2'b00, 2, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 2'b00, 3, 0,  0, 0, 0, 0, 1, 0, 0};  // clean done
    vecs[6]  = '{0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 4, 0, 2'b00, 0, 0,  1, 0, 0, 1, 0, 0, 0};  // T2 start
    vecs[8]  = '{0, 0, 0, 1, 2'b00, 0, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 2'b00, 1, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 2'b10, 2, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 2'b00, 3, 0,  1, 1, 2, 1, 0, 0, 1};  // enter RESEND
    vecs[12] = '{0, 0, 0, 0, 2'b00, 0, 1,  1, 0, 0, 1, 0, 0, 1};  // resend accepted
    vecs[13] = '{0, 0, 0, 1, 2'b00, 2, 0,  0, 0, 0, 0, 1, 0, 1};  // OKAY replay -> done
    vecs[14] = '{0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 1};
    vecs[15] = '{0, 1, 0, 0, 2'b00, 0, 0,  1, 0, 0, 1, 0, 0, 0};  // T5 start_cnt=0
    vecs[16] = '{0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].cnt, vecs[i].bv, vecs[i].br, vecs[i].ba, vecs[i].rr);
      check($sformatf("vec%0d", i), vecs[i].e_brdy, vecs[i].e_rsv, vecs[i].e_addr,
            vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err, vecs[i].e_retry);
    end

    // T3: out-of-order errors, resend backpressure, responses arriving during RESEND
    drive(0, 1, 4, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 1, 2'b10, 200, 0);
    drive(0, 0, 0, 1, 2'b11, 5, 0);
    drive(0, 0, 0, 1, 2'b01, 37, 0);
    drive(0, 0, 0, 1, 2'b00, 100, 0);
    check("t3.enter", 1, 1, 5, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 2'b00, 0, 0);
      check($sformatf("t3.hold%0d", i), 1, 1, 5, 1, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 2'b00, 0, 1);
    check("t3.after5", 1, 1, 37, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 2'b00, 5, 1);
    check("t3.after37", 1, 1, 200, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 2'b00, 37, 1);
    check("t3.after200", 1, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 2'b00, 200, 0);
    check("t3.done", 0, 0, 0, 0, 1, 0, 1);

    // T4: address 9 fails every round until retries run out
    drive(0, 1, 1, 0, 2'b00, 0, 0);
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 1, 2'b10, 9, 0);
      check($sformatf("t4.round%0d", r), 1, 1, 9, 1, 0, 0, 2'(r));
      drive(0, 0, 0, 0, 2'b00, 0, 1);
      check($sformatf("t4.issued%0d", r), 1, 0, 0, 1, 0, 0, 2'(r));
    end
    drive(0, 0, 0, 1, 2'b10, 9, 0);
    check("t4.exhaust", 0, 0, 0, 0, 1, 1, 3);
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    check("t4.pulse_end", 0, 0, 0, 0, 0, 0, 3);

    // T5: start_cnt=300 saturates to 256; a start in the middle must be ignored
    drive(0, 1, 300, 0, 2'b00, 0, 0);
    check("t5.sat_start", 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(0, (i == 10), 1, 1, 2'b00, 8'(i), 0);
      if (i == 254) check("t5.sat_busy", 1, 0, 0, 1, 0, 0, 0);
      if (i == 255) check("t5.sat_done", 0, 0, 0, 0, 1, 0, 0);
    end

    // T6: reset while a resend is pending aborts without done/err
    drive(0, 1, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 1, 2'b10, 50, 0);
    check("t6.pre", 1, 1, 50, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 2'b00, 0, 0);
    check("t6.reset", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2'b10, 50, 0);
    check("t6.idle", 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
